// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the flexible synchronous FIFO.
// ptr_w gives the pointer width: the address bits plus one wrap bit.
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// FIFO storage: one synchronous write port and one asynchronous read port.
// There is no reset, because flush and rst only move the pointers.
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered-read or first-word-fall-through output,
// occupancy count, almost thresholds, sticky error flags and synchronous flush.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int         WIDTH     = 8,
  parameter int         DEPTH     = 16,
  parameter fifo_mode_e MODE      = FIFO_STD,
  parameter int         AF_THRESH = DEPTH - 2,
  parameter int         AE_THRESH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      w_en,
  input  logic [WIDTH-1:0]          din,
  input  logic                      r_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_flex: DEPTH must be a power of two and at least 2");
  end
  if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
    $error("sync_fifo_flex: AF_THRESH must lie in 1..DEPTH");
  end
  if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
    $error("sync_fifo_flex: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [PW-1:0]    w_ptr_q, w_ptr_d;
  logic [PW-1:0]    r_ptr_q, r_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [WIDTH-1:0] ram_rdata;
  logic             rd_ok, wr_ok;

  // Status comes from the registered pointers only, never from this cycle's requests.
  always_comb begin
    count        = w_ptr_q - r_ptr_q;
    full         = (count == PW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= PW'(AF_THRESH));
    almost_empty = (count <= PW'(AE_THRESH));
  end

  // Handshake: w_en/r_en are requests, and wr_ok/rd_ok are their acceptance,
  // judged on pre-edge state. A rejected request outside flush sets the sticky
  // overflow/underflow flag. A full FIFO still takes a write when a read is
  // accepted in the same cycle.
  always_comb begin
    rd_ok = r_en && !empty && !flush;
    wr_ok = w_en && !flush && (!full || rd_ok);
  end

  always_comb begin
    w_ptr_d      = w_ptr_q;
    r_ptr_d      = r_ptr_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    if (flush) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_ok) w_ptr_d = w_ptr_q + PW'(1);
      if (rd_ok) r_ptr_d = r_ptr_q + PW'(1);
      if (w_en && !wr_ok) overflow_d = 1'b1;
      if (r_en && !rd_ok) underflow_d = 1'b1;
    end
    if (rd_ok) begin
      dout_d       = ram_rdata;
      dout_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q      <= '0;
      r_ptr_q      <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      w_ptr_q      <= w_ptr_d;
      r_ptr_q      <= r_ptr_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr_q[AW-1:0]),
    .wdata (din),
    .raddr (r_ptr_q[AW-1:0]),
    .rdata (ram_rdata)
  );

  // In FWFT mode the head word is presented directly, without the output register.
  always_comb begin
    overflow  = overflow_q;
    underflow = underflow_q;
    if (MODE == FIFO_FWFT) begin
      dout       = ram_rdata;
      dout_valid = !empty;
    end else begin
      dout       = dout_q;
      dout_valid = dout_valid_q;
    end
  end

endmodule
